collision_generator: RTL and testbench

Produces the `collision` input consumed by the player health state machine. Once per video frame it tests the player bounding box against every active bullet. On a hit it asserts `collision` for a fixed number of frames, then enforces an invulnerability cooldown. This guarantees the health tracker sees exactly one clean high-then-low episode per hit. It sits between the sprite/bullet position logic and the health tracker, and also tells the bullet logic which bullet to retire.

---
 rtl/collision_generator_pkg.sv | 14 +
 rtl/collision_generator_frame_tick_sync.sv | 30 +++
 rtl/collision_generator.sv | 125 ++++++++++++
 tb/tb_collision_generator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/collision_generator_pkg.sv
// Shared types and default geometry for the collision generator and the bullet logic.
package collision_pkg;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        HIT      = 2'd1,
        COOLDOWN = 2'd2,
        DEAD     = 2'd3
    } coll_state_t;

    localparam int DEF_COORD_W     = 10;
    localparam int DEF_NUM_BULLETS = 4;

endpackage

// File: rtl/collision_generator_frame_tick_sync.sv
// Brings the asynchronous frame strobe into the Clk domain and emits a
// one-cycle pulse per rising edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic s1, s2, s3, primed;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            primed <= 1'b0;
        end else begin
            s1 <= frame_clk;
            s2 <= s1;
            s3 <= s2;
            if (!s2)
                primed <= 1'b1;
        end
    end

    // A strobe level held high straight through reset is not a fresh edge.
    assign frame_tick = s2 & ~s3 & primed;

endmodule

// File: rtl/collision_generator.sv
// Once-per-frame player/bullet overlap test feeding the health tracker with
// one clean collision episode per hit, followed by an invulnerability window.
module collision_generator
    import collision_pkg::*;
#(
    parameter int COORD_W         = DEF_COORD_W,
    parameter int NUM_BULLETS     = DEF_NUM_BULLETS,
    parameter int PLAYER_HALF     = 8,
    parameter int BULLET_HALF     = 2,
    parameter int HOLD_FRAMES     = 2,
    parameter int COOLDOWN_FRAMES = 60,
    localparam int IDX_W          = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           frame_clk,
    input  logic [COORD_W-1:0]             player_x,
    input  logic [COORD_W-1:0]             player_y,
    input  logic [NUM_BULLETS*COORD_W-1:0] bullet_x,
    input  logic [NUM_BULLETS*COORD_W-1:0] bullet_y,
    input  logic [NUM_BULLETS-1:0]         bullet_active,
    input  logic                           gameEnd,
    output logic                           collision,
    output logic [IDX_W-1:0]               hit_index,
    output logic [NUM_BULLETS-1:0]         bullet_clear,
    output logic                           invuln
);

    localparam int CNT_MAX = (HOLD_FRAMES > COOLDOWN_FRAMES) ? HOLD_FRAMES : COOLDOWN_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [COORD_W:0] REACH = (COORD_W+1)'(PLAYER_HALF + BULLET_HALF);

    logic                   frame_tick;
    logic [NUM_BULLETS-1:0] overlap;
    logic                   hit_any;
    logic [IDX_W-1:0]       hit_sel;
    coll_state_t            state;
    logic [CNT_W-1:0]       cnt;

    frame_tick_sync u_sync (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    // One extra bit keeps the difference signed so screen-edge wrap cannot alias into range.
    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        logic signed [COORD_W:0] dx, dy;
        logic        [COORD_W:0] ax, ay;
        assign dx = $signed({1'b0, player_x}) - $signed({1'b0, bullet_x[g*COORD_W +: COORD_W]});
        assign dy = $signed({1'b0, player_y}) - $signed({1'b0, bullet_y[g*COORD_W +: COORD_W]});
        assign ax = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
        assign ay = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
        assign overlap[g] = bullet_active[g] && (ax <= REACH) && (ay <= REACH);
    end

    always_comb begin
        hit_any = 1'b0;
        hit_sel = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (overlap[i]) begin
                hit_any = 1'b1;
                hit_sel = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= ARMED;
            cnt          <= '0;
            collision    <= 1'b0;
            invuln       <= 1'b0;
            hit_index    <= '0;
            bullet_clear <= '0;
        end else begin
            bullet_clear <= '0;
            if (gameEnd) begin
                state     <= DEAD;
                cnt       <= '0;
                collision <= 1'b0;
                invuln    <= 1'b0;
                hit_index <= '0;
            end else begin
                case (state)
                    ARMED: begin
                        if (frame_tick && hit_any) begin
                            state        <= HIT;
                            cnt          <= CNT_W'(HOLD_FRAMES);
                            collision    <= 1'b1;
                            invuln       <= 1'b1;
                            hit_index    <= hit_sel;
                            bullet_clear <= NUM_BULLETS'(1) << hit_sel;
                        end
                    end
                    HIT: begin
                        if (frame_tick) begin
                            if (cnt == CNT_W'(1)) begin
                                state     <= COOLDOWN;
                                cnt       <= CNT_W'(COOLDOWN_FRAMES);
                                collision <= 1'b0;
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end
                    end
                    COOLDOWN: begin
                        if (frame_tick) begin
                            if (cnt == CNT_W'(1)) begin
                                state  <= ARMED;
                                cnt    <= '0;
                                invuln <= 1'b0;
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_collision_generator.sv
// Directed and randomized frames against a frame-level reference model of the hit/hold/cooldown rules.
module tb_collision_generator;

    localparam int CW    = 10;
    localparam int NB    = 4;
    localparam int HOLD  = 2;
    localparam int COOL  = 60;
    localparam int REACH = 10;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic            frame_clk = 1'b0;
    logic [CW-1:0]   player_x = '0, player_y = '0;
    logic [NB*CW-1:0] bullet_x = '0, bullet_y = '0;
    logic [NB-1:0]   bullet_active = '0;
    logic            gameEnd = 1'b0;
    logic            collision;
    logic [1:0]      hit_index;
    logic [NB-1:0]   bullet_clear;
    logic            invuln;

    collision_generator dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .player_x      (player_x),
        .player_y      (player_y),
        .bullet_x      (bullet_x),
        .bullet_y      (bullet_y),
        .bullet_active (bullet_active),
        .gameEnd       (gameEnd),
        .collision     (collision),
        .hit_index     (hit_index),
        .bullet_clear  (bullet_clear),
        .invuln        (invuln)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: tick count, tick of the last hit, sticky death.
    int   tick_no = 0;
    int   hit_tick = -1;
    bit   dead = 1'b0;
    int   m_idx = 0;
    logic [NB-1:0] m_clear = '0;
    int   bx [NB];
    int   by [NB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_bullet(input int i, input int x, input int y, input bit a);
        bx[i] = x;
        by[i] = y;
        bullet_x[i*CW +: CW] = CW'(x);
        bullet_y[i*CW +: CW] = CW'(y);
        bullet_active[i] = a;
    endtask

    function automatic bit ref_overlap(input int i);
        int ddx, ddy;
        ddx = int'(player_x) - bx[i];
        ddy = int'(player_y) - by[i];
        if (ddx < 0) ddx = -ddx;
        if (ddy < 0) ddy = -ddy;
        return bullet_active[i] && ddx <= REACH && ddy <= REACH;
    endfunction

    task automatic model_tick();
        tick_no++;
        m_clear = '0;
        if (!dead && gameEnd) begin
            dead = 1'b1;
        end else if (!dead && (hit_tick < 0 || tick_no > hit_tick + HOLD + COOL)) begin
            for (int i = 0; i < NB; i++) begin
                if (ref_overlap(i) && m_clear == '0) begin
                    hit_tick = tick_no;
                    m_idx    = i;
                    m_clear  = NB'(1) << i;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag, input logic [NB-1:0] exp_clear);
        bit ec, ei;
        ec = !dead && hit_tick >= 0 && tick_no < hit_tick + HOLD;
        ei = !dead && hit_tick >= 0 && tick_no < hit_tick + HOLD + COOL;
        chk({tag, ".collision"}, 32'(collision), 32'(ec));
        chk({tag, ".invuln"}, 32'(invuln), 32'(ei));
        chk({tag, ".hit_index"}, 32'(hit_index), dead ? 32'd0 : 32'(m_idx));
        chk({tag, ".bullet_clear"}, 32'(bullet_clear), 32'(exp_clear));
    endtask

    // One frame strobe; the tick occupies the cycle after the second sampling edge.
    task automatic frame(input string tag);
        @(negedge Clk) frame_clk = 1'b1;
        repeat (2) @(posedge Clk);
        model_tick();
        @(posedge Clk); #1;
        check_outputs(tag, m_clear);
        @(posedge Clk); #1;
        chk({tag, ".clear_pulse_end"}, 32'(bullet_clear), 32'd0);
        @(negedge Clk) frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge Clk) Reset = 1'b1;
        #1;
        chk({tag, ".rst_collision"}, 32'(collision), 32'd0);
        chk({tag, ".rst_invuln"}, 32'(invuln), 32'd0);
        chk({tag, ".rst_hit_index"}, 32'(hit_index), 32'd0);
        chk({tag, ".rst_bullet_clear"}, 32'(bullet_clear), 32'd0);
        hit_tick = -1;
        dead     = 1'b0;
        m_idx    = 0;
        @(negedge Clk) Reset = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic clear_bullets();
        for (int i = 0; i < NB; i++) set_bullet(i, 0, 0, 1'b0);
    endtask

    initial begin
        int px, py;
        clear_bullets();
        repeat (3) @(negedge Clk);
        do_reset("init");

        // Single hit on slot 0, then 63 empty frames cover hold and cooldown edges.
        player_x = 100; player_y = 100;
        set_bullet(0, 108, 102, 1'b1);
        frame("hit0");
        clear_bullets();
        for (int f = 0; f < 63; f++) frame("hit0_decay");

        // Just outside reach: no hit.
        set_bullet(0, 111, 100, 1'b1);
        for (int f = 0; f < 5; f++) frame("miss11");

        // Exactly at reach on both axes, held for 100 frames: hits only at the re-arm points.
        set_bullet(0, 110, 110, 1'b1);
        for (int f = 0; f < 100; f++) frame("continuous");
        clear_bullets();
        for (int f = 0; f < 30; f++) frame("drain");

        // Unsigned wrap must not alias 1020 next to 2.
        player_x = 2; player_y = 100;
        set_bullet(0, 1020, 100, 1'b1);
        for (int f = 0; f < 3; f++) frame("wrap");
        clear_bullets();

        // Slots 1 and 3 both overlap: lowest index wins.
        player_x = 300; player_y = 300;
        set_bullet(1, 305, 295, 1'b1);
        set_bullet(3, 300, 300, 1'b1);
        frame("prio");

        // Reset in the middle of the hold; no hit until a new strobe edge.
        do_reset("midhit");
        for (int c = 0; c < 20; c++) begin
            @(posedge Clk); #1;
            chk("post_reset_idle.collision", 32'(collision), 32'd0);
        end
        frame("post_reset_hit");
        clear_bullets();

        // Randomized geometry and masks.
        do_reset("rand");
        for (int f = 0; f < 150; f++) begin
            px = $urandom_range(50, 950);
            py = $urandom_range(50, 950);
            player_x = CW'(px); player_y = CW'(py);
            for (int i = 0; i < NB; i++)
                set_bullet(i, px + $urandom_range(0, 28) - 14, py + $urandom_range(0, 28) - 14,
                           1'($urandom_range(0, 3) == 0));
            frame("rand");
        end

        // gameEnd rising during HIT drops collision on the next edge.
        do_reset("ge_hit");
        clear_bullets();
        player_x = 500; player_y = 500;
        set_bullet(2, 500, 500, 1'b1);
        frame("ge_hit_entry");
        @(negedge Clk) gameEnd = 1'b1;
        @(posedge Clk); #1;
        dead = 1'b1;
        check_outputs("ge_hit_drop", '0);
        gameEnd = 1'b0;

        // gameEnd in the same tick as an overlap: silent, and stays silent.
        do_reset("ge_same");
        gameEnd = 1'b1;
        frame("ge_same_tick");
        gameEnd = 1'b0;
        for (int f = 0; f < 3; f++) frame("dead_silent");
        do_reset("final");
        frame("revived");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
